// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read-port bundle between the async FIFO read side and the UART drain.
// The drain is the master: it observes EMPTY/RD_DATA and issues RD_INC.
interface uart_tx_fifo_drain_if #(
    parameter int WIDTH = 8
);
    logic             FIFO_EMPTY;
    logic [WIDTH-1:0] FIFO_RD_DATA;
    logic             FIFO_RD_INC;

    modport master (
        input  FIFO_EMPTY,
        input  FIFO_RD_DATA,
        output FIFO_RD_INC
    );

    modport slave (
        output FIFO_EMPTY,
        output FIFO_RD_DATA,
        input  FIFO_RD_INC
    );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// Pops words from a FWFT FIFO read port and serialises each as a UART frame:
// start, data LSB first, optional parity, stop. Bit timing from TICK.
module uart_tx_fifo_drain #(
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    uart_tx_fifo_drain_if.master fifo,
    input  logic                 TICK,
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
    output logic                 TX_OUT,
    output logic                 BUSY
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift;
    logic [CW-1:0]    cnt;
    logic             par_en_q;
    logic             par_bit;

    // Parity is fixed at load so mid-frame config changes cannot leak in.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state            <= IDLE;
            shift            <= '0;
            cnt              <= '0;
            par_en_q         <= 1'b0;
            par_bit          <= 1'b0;
            fifo.FIFO_RD_INC <= 1'b0;
            TX_OUT           <= 1'b1;
            BUSY             <= 1'b0;
        end else begin
            fifo.FIFO_RD_INC <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!fifo.FIFO_EMPTY) begin
                        shift            <= fifo.FIFO_RD_DATA;
                        par_en_q         <= PAR_EN;
                        par_bit          <= (^fifo.FIFO_RD_DATA) ^ PAR_TYP;
                        fifo.FIFO_RD_INC <= 1'b1;
                        BUSY             <= 1'b1;
                        state            <= WAIT;
                    end
                end
                WAIT: begin
                    if (TICK) begin
                        TX_OUT <= 1'b0;
                        state  <= START;
                    end
                end
                START: begin
                    if (TICK) begin
                        cnt    <= '0;
                        TX_OUT <= shift[0];
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (TICK) begin
                        shift <= shift >> 1;
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            if (par_en_q) begin
                                TX_OUT <= par_bit;
                                state  <= PARITY;
                            end else begin
                                TX_OUT <= 1'b1;
                                state  <= STOP;
                            end
                        end else begin
                            TX_OUT <= shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (TICK) begin
                        TX_OUT <= 1'b1;
                        state  <= STOP;
                    end
                end
                STOP: begin
                    if (TICK) begin
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
